// File: rtl/fir_driver.sv
// fir_driver: valid/ready sequencer that winds, loads and fires the 16-tap fir block.
// Build option FIR_DRIVER_PRIME_EN suppresses results until the filter history is full.
module fir_driver #(
    parameter int TAPS    = 16,
    parameter int TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        cfg_start,
    input  logic        w_valid,
    output logic        w_ready,
    input  logic [15:0] w_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    output logic        r_valid,
    input  logic        r_ready,
    output logic [15:0] r_data,
    output logic        err,
    output logic        wind,
    output logic        load,
    output logic        in_valid,
    output logic [15:0] data,
    input  logic        out_valid,
    input  logic [15:0] out
);

    localparam int CW = $clog2(TAPS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] WLAST = CW'(TAPS - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WLOAD = 3'd1;
    localparam logic [2:0] READY = 3'd2;
    localparam logic [2:0] SHIFT = 3'd3;
    localparam logic [2:0] FIRE  = 3'd4;
    localparam logic [2:0] WAIT  = 3'd5;
    localparam logic [2:0] PUSH  = 3'd6;

    logic [2:0]    state;
    logic [CW-1:0] wcnt;
    logic [1:0]    fcnt;
    logic [TW-1:0] tcnt;
    logic          cfg_ok;
    logic          s_acc;
    logic          fire_ok;

    assign w_ready = (state == WLOAD);
    assign s_ready = (state == READY);
    assign r_valid = (state == PUSH);

    assign cfg_ok = cfg_start && ((state == IDLE) || (state == READY));
    assign s_acc  = s_ready && s_valid && !cfg_start;

`ifdef FIR_DRIVER_PRIME_EN
    localparam logic [CW-1:0] PFULL = CW'(TAPS);

    // Saturating count of samples loaded since the last weight burst
    logic [CW-1:0] pcnt;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pcnt <= '0;
        end else if (cfg_ok) begin
            pcnt <= '0;
        end else if (s_acc && (pcnt != PFULL)) begin
            pcnt <= pcnt + 1'b1;
        end
    end

    assign fire_ok = (pcnt == PFULL);
`else
    assign fire_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state    <= IDLE;
            wcnt     <= '0;
            fcnt     <= '0;
            tcnt     <= '0;
            wind     <= 1'b0;
            load     <= 1'b0;
            in_valid <= 1'b0;
            data     <= '0;
            r_data   <= '0;
            err      <= 1'b0;
        end else begin
            wind <= 1'b0;
            load <= 1'b0;
            if (cfg_ok) begin
                state <= WLOAD;
                wcnt  <= '0;
                err   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    WLOAD: begin
                        if (w_valid) begin
                            data <= w_data;
                            wind <= 1'b1;
                            if (wcnt == WLAST) begin
                                state <= READY;
                            end else begin
                                wcnt <= wcnt + 1'b1;
                            end
                        end
                    end
                    READY: begin
                        if (s_acc) begin
                            data  <= s_data;
                            load  <= 1'b1;
                            state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (fire_ok) begin
                            in_valid <= 1'b1;
                            fcnt     <= '0;
                            state    <= FIRE;
                        end else begin
                            state <= READY;
                        end
                    end
                    FIRE: begin
                        // One in_valid cycle per group of four taps
                        if (fcnt == 2'd3) begin
                            in_valid <= 1'b0;
                            tcnt     <= '0;
                            state    <= WAIT;
                        end else begin
                            fcnt <= fcnt + 1'b1;
                        end
                    end
                    WAIT: begin
                        if (out_valid) begin
                            r_data <= out;
                            state  <= PUSH;
                        end else if (tcnt == TLAST) begin
                            err   <= 1'b1;
                            state <= READY;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    PUSH: begin
                        if (r_ready) begin
                            state <= READY;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fir_driver.sv
// tb_fir_driver: randomized stimulus for fir_driver, a stand-in fir filter and
// a convolution reference model over the full sample history.
module tb_fir_driver;

    localparam int TAPS    = 16;
    localparam int TIMEOUT = 32;
    localparam int RESP    = 8;

`ifdef FIR_DRIVER_PRIME_EN
    localparam bit PRIME = 1'b1;
`else
    localparam bit PRIME = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstb = 1'b1;
    logic        cfg_start = 1'b0;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic [15:0] w_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = '0;
    logic        r_valid;
    logic        r_ready = 1'b0;
    logic [15:0] r_data;
    logic        err;
    logic        wind;
    logic        load;
    logic        in_valid;
    logic [15:0] data;
    logic        out_valid = 1'b0;
    logic [15:0] fout = '0;

    always #5 clk = ~clk;

    fir_driver #(.TAPS(TAPS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstb(rstb), .cfg_start(cfg_start),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .err(err), .wind(wind), .load(load), .in_valid(in_valid),
        .data(data), .out_valid(out_valid), .out(fout)
    );

    int errs = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Stand-in filter: shift registers sampled on negedge, fixed response delay
    logic [15:0] fw [TAPS] = '{default: '0};
    logic [15:0] fx [TAPS] = '{default: '0};
    logic [15:0] facc = '0;
    logic        stall = 1'b0;
    logic        iv_q = 1'b0;
    int          cd = 0;
    int          iv_cnt = 0;

    always @(negedge clk) begin
        out_valid = 1'b0;
        if (wind) begin
            for (int i = TAPS - 1; i > 0; i--) fw[i] = fw[i-1];
            fw[0] = data;
        end
        if (load) begin
            for (int i = TAPS - 1; i > 0; i--) fx[i] = fx[i-1];
            fx[0] = data;
        end
        if (in_valid) iv_cnt++;
        if (in_valid && !iv_q) begin
            facc = '0;
            for (int i = 0; i < TAPS; i++) facc = facc + fw[i] * fx[i];
            cd = RESP;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0 && !stall) begin
                out_valid = 1'b1;
                fout = facc;
            end
        end
        iv_q = in_valid;
    end

    // Cycle-wise invariants
    logic [15:0] pdata = '0;
    logic [15:0] prd = '0;
    logic        prv = 1'b0;
    logic        perr = 1'b0;
    logic        prst = 1'b0;

    always @(negedge clk) begin
        check("excl", 32'($countones({wind, load, in_valid}) <= 1), 1);
        if (rstb && prst) begin
            if (!wind && !load) check("data_hold", data, pdata);
            if (prv && !r_ready) check("r_stable", {r_valid, err, r_data}, {prv, perr, prd});
        end
        pdata = data;
        prd   = r_data;
        prv   = r_valid;
        perr  = err;
        prst  = rstb;
    end

    // Reference model: tap weights and every sample ever loaded
    logic [15:0] wref [TAPS] = '{default: '0};
    logic [15:0] wq   [TAPS];
    logic [15:0] hist [$];
    int          pc = 0;
    int          nres = 0;
    logic [15:0] last_r = '0;
    logic        err_exp = 1'b0;

    function automatic logic [15:0] ref_out();
        logic [15:0] s;
        int n;
        s = '0;
        n = hist.size() - 1;
        for (int i = 0; i < TAPS; i++)
            if (n - i >= 0) s = s + wref[i] * hist[n-i];
        return s;
    endfunction

    task automatic burst();
        check("err_pre", err, err_exp);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("wl_enter", {w_ready, s_ready, err, wind}, 4'b1000);
        err_exp = 1'b0;
        pc = 0;
        for (int k = 0; k < TAPS; k++) begin
            while ($urandom_range(0, 3) == 0) begin
                w_valid = 1'b0;
                tick();
                check("w_gap", {w_ready, wind}, 2'b10);
            end
            w_valid = 1'b1;
            w_data = wq[k];
            tick();
            check("wind", {wind, w_ready}, {1'b1, (k != TAPS - 1)});
            check("wdata", data, wq[k]);
            wref[TAPS-1-k] = wq[k];
        end
        w_valid = 1'b0;
        check("w_done", s_ready, 1);
    endtask

    task automatic wait_sready();
        int t;
        t = 0;
        while (!s_ready && t < 50) begin
            tick();
            t++;
        end
        check("s_ready_wait", s_ready, 1);
    endtask

    task automatic run_sample(input logic [15:0] v, input int bp, input bit poke);
        int t;
        bit bad;
        bit f;
        logic [15:0] want;
        wait_sready();
        if (poke) begin
            w_valid = 1'b1;
            w_data = 16'($urandom);
            repeat (3) begin
                tick();
                check("w_ignored", {w_ready, wind, s_ready}, 3'b001);
            end
            w_valid = 1'b0;
        end
        s_valid = 1'b1;
        s_data = v;
        tick();
        s_valid = 1'b0;
        hist.push_back(v);
        if (pc < TAPS) pc++;
        f = !PRIME || (pc >= TAPS);
        want = ref_out();
        check("load", {load, s_ready, in_valid}, 3'b100);
        check("ldata", data, v);
        tick();
        if (!f) begin
            check("prime_skip", {s_ready, in_valid, load}, 3'b100);
            return;
        end
        for (int i = 0; i < 4; i++) begin
            check("fire", {in_valid, load, wind, s_ready}, 4'b1000);
            if (i < 3) tick();
        end
        t = 0;
        bad = 1'b0;
        if (stall) begin
            while (!err && t < TIMEOUT + 10) begin
                tick();
                t++;
                if (r_valid) bad = 1'b1;
            end
            check("to_lat", t, TIMEOUT + 1);
            check("to_state", {err, s_ready, r_valid, bad}, 4'b1100);
            err_exp = 1'b1;
            return;
        end
        r_ready = (bp == 0);
        while (!r_valid && t < TIMEOUT + 10) begin
            if (poke && t == 1) cfg_start = 1'b1;
            tick();
            if (cfg_start) check("cfg_ignored", {w_ready, wind}, 2'b00);
            cfg_start = 1'b0;
            t++;
        end
        check("r_lat", t, RESP - 2);
        check("r_data", {r_valid, s_ready, r_data}, {2'b10, want});
        nres++;
        last_r = r_data;
        for (int i = 0; i < bp; i++) begin
            tick();
            check("bp_hold", {r_valid, s_ready, r_data}, {2'b10, want});
        end
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        check("r_done", {r_valid, s_ready}, 2'b01);
    endtask

    initial begin
        int r0;
        int iv0;
        bit bad;
        logic [15:0] v;

        #1 rstb = 1'b0;
        tick();
        tick();
        check("rst_ctl", {w_ready, s_ready, r_valid, err, wind, load, in_valid}, 0);
        check("rst_data", data, 0);
        check("rst_rdata", r_data, 0);
        rstb = 1'b1;
        tick();
        check("idle", {s_ready, w_ready}, 2'b00);

        // Impulse through ascending weights
        for (int k = 0; k < TAPS; k++) wq[k] = 16'(k + 1);
        burst();
        iv0 = iv_cnt;
        for (int n = 0; n < TAPS; n++) begin
            r0 = nres;
            run_sample((n == 0) ? 16'd1 : 16'd0, 0, 1'b0);
            if (nres != r0) check("imp_seq", last_r, 16 - n);
            if (n == TAPS - 2) check("imp_iv", iv_cnt - iv0, PRIME ? 0 : 4 * (TAPS - 1));
        end
        check("imp_count", nres, PRIME ? 1 : TAPS);

        run_sample(16'($urandom), 20, 1'b0);
        run_sample(16'($urandom), 0, 1'b1);

        stall = 1'b1;
        run_sample(16'($urandom), 0, 1'b0);
        stall = 1'b0;
        run_sample(16'($urandom), 1, 1'b0);
        check("err_sticky", err, 1);

        // Reload from READY with random weights and samples
        for (int k = 0; k < TAPS; k++) wq[k] = 16'($urandom);
        burst();
        for (int n = 0; n < 24; n++) run_sample(16'($urandom), $urandom_range(0, 3), 1'b0);

        // Asynchronous reset during the second in_valid cycle
        wait_sready();
        v = 16'($urandom);
        s_valid = 1'b1;
        s_data = v;
        tick();
        s_valid = 1'b0;
        hist.push_back(v);
        tick();
        tick();
        check("mid_fire", in_valid, 1);
        rstb = 1'b0;
        #1;
        check("arst_ctl", {w_ready, s_ready, r_valid, err, wind, load, in_valid}, 0);
        check("arst_data", {data, r_data}, 0);
        pc = 0;
        err_exp = 1'b0;
        tick();
        tick();
        rstb = 1'b1;
        bad = 1'b0;
        repeat (4) begin
            tick();
            if (s_ready || w_ready) bad = 1'b1;
        end
        check("post_rst_idle", bad, 0);
        for (int k = 0; k < TAPS; k++) wq[k] = 16'($urandom);
        burst();
        for (int n = 0; n < 4; n++) run_sample(16'($urandom), $urandom_range(0, 2), 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
